if_id_decode_stage: RTL and testbench
=====================================

// Module: if_id_decode_stage
// PURPOSE
//  IF/ID pipeline register and decode stage, directly downstream of instruction fetch.
//  Registers each fetched 32-bit word, splits it into opcode, register and immediate fields.
//  Detects load-use hazards and stalls fetch. Flushes on taken branch.
//  Sequences processor halt when fetch reports the halt opcode.
// PARAMETERS
//  DATA_W        32        instruction/immediate width
//  PC_W          7         instruction address width (99-entry instruction memory)
//  REG_AW        4         register index width
//  DRAIN_CYCLES  3         cycles between halt detection and halted assertion (EX/MEM/WB drain)
// PORTS
//  clk          in   1       single clock, all state on rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  if_instr     in   32      instruction word from fetch
//  if_pc        in   PC_W    address of if_instr
//  if_valid     in   1       if_instr is a real instruction this cycle
//  if_done      in   1       fetch reached halt opcode 5'b01011
//  ex_stall     in   1       downstream cannot accept; hold ID outputs
//  br_flush     in   1       taken branch resolved; squash ID and hold contents
//  id_valid     out  1       ID outputs carry a real instruction
//  id_opcode    out  5       instr[31:27]
//  id_rd        out  REG_AW  instr[26:23]
//  id_rs1       out  REG_AW  instr[22:19]
//  id_rs2       out  REG_AW  instr[18:15]
//  id_imm       out  32      instr[14:0] sign-extended
//  id_pc        out  PC_W    pc of ID instruction
//  stall_fetch  out  1       combinational; fetch must not advance pc
//  halted       out  1       sticky; pipeline drained after halt
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0. Hold buffer empty. FSM=RUN. Drain counter 0.
//  Latency: if_instr at edge N -> id_* valid after edge N+1.
//  Per-cycle priority: br_flush > ex_stall > load-use > normal capture.
//  - br_flush: next id_valid=0. Hold buffer emptied. Same-cycle if_instr discarded.
//    If FSM=DRAIN: return to RUN, counter cleared. No effect once HALTED.
//  - ex_stall: id_* held unchanged. stall_fetch=1.
//    If hold buffer empty and if_valid=1: capture if_instr/if_pc into hold.
//  - load-use: ID holds valid opcode LOAD (5'b00100) with rd!=0, and source rd==rs1 or rd==rs2.
//    Source = hold buffer if full, else if_instr.
//    Response: stall_fetch=1. Next id_valid=0 (bubble). Source moved/kept in hold.
//  - normal: source is hold (if full, hold then empties), else if_instr when if_valid.
//    id_valid = source valid.
//  - Hold buffer: 1 entry, never overwritten while full.
//    Full + new if_valid + stall_fetch=1: new word ignored; fetch must re-present it.
//  Halt FSM, RUN -> DRAIN -> HALTED:
//  - RUN: if_done=1 -> DRAIN. From then on if_valid ignored; hold still issues.
//  - DRAIN: counter increments only when ex_stall=0 and hold empty.
//    At DRAIN_CYCLES -> HALTED, halted=1.
//  - HALTED: id_valid=0, stall_fetch=1, only rst_n exits.
//  - if_done and br_flush same cycle: flush wins, FSM stays RUN.
//  rst_n asserted mid-stall/drain: immediate return to reset values, no partial state kept.
//  id_imm = {{17{instr[14]}}, instr[14:0]}. No truncation of other fields.
// STRUCTURE
//  cpu_pkg shared package holds:
//   opcode enum (LOAD=5'b00100, HALT=5'b01011, ...), field bit positions, REG_AW, PC_W.
//  One sub-module id_hazard_detect: combinational load-use compare -> hazard flag.
//  Rest is flat: pipeline regs, hold buffer, halt FSM.
// TESTING
//  1. ADD at pc 0..3, no stalls -> id_valid=1 one cycle after each; fields/imm exact (imm 0x7FFF -> 0xFFFFFFFF).
//  2. LOAD rd=5 then ADD rs1=5 -> stall_fetch=1 one cycle; one bubble; ADD issues next with id_pc=1.
//  3. ex_stall=1 for 3 cycles mid-stream -> id_* frozen; hold captures next word; order preserved, none lost.
//  4. br_flush with hold full -> next id_valid=0, hold empty; next if_instr issues normally.
//  5. if_done=1 at cycle 10, no stalls -> halted=1 at cycle 10+DRAIN_CYCLES+1; stays 1; stall_fetch=1.
//  6. rst_n low in DRAIN, async mid-cycle -> outputs 0 immediately; after release FSM=RUN, halted=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, instruction field layout and
// the halt-sequencing state encoding used by the decode stage.
package cpu_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_AW   = 7;
    localparam int unsigned RF_AW   = 4;
    localparam int unsigned OPC_W   = 5;
    localparam int unsigned IMM_W   = 15;

    localparam int unsigned OPC_LSB = 27;
    localparam int unsigned RD_LSB  = 23;
    localparam int unsigned RS1_LSB = 19;
    localparam int unsigned RS2_LSB = 15;
    localparam int unsigned IMM_LSB = 0;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP   = 5'b00000,
        OP_ADD   = 5'b00001,
        OP_SUB   = 5'b00010,
        OP_LOAD  = 5'b00100,
        OP_STORE = 5'b00101,
        OP_BEQ   = 5'b01000,
        OP_HALT  = 5'b01011
    } opcode_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } halt_state_e;

    function automatic logic [INSTR_W-1:0] sext_imm(input logic [INSTR_W-1:0] instr);
        return {{(INSTR_W-IMM_W){instr[IMM_LSB+IMM_W-1]}}, instr[IMM_LSB +: IMM_W]};
    endfunction

endpackage

// File: rtl/id_hazard_detect.sv
// Load-use hazard compare: the instruction sitting in ID is a LOAD whose
// destination is read by the next instruction to be issued.
module id_hazard_detect
    import cpu_pkg::*;
(
    input  logic             id_valid,
    input  logic [OPC_W-1:0] id_opcode,
    input  logic [RF_AW-1:0] id_rd,
    input  logic             src_valid,
    input  logic [RF_AW-1:0] src_rs1,
    input  logic [RF_AW-1:0] src_rs2,
    output logic             hazard
);

    always_comb begin
        hazard = id_valid && src_valid && (id_opcode == OP_LOAD) && (id_rd != '0) &&
                 ((id_rd == src_rs1) || (id_rd == src_rs2));
    end

endmodule

// File: rtl/if_id_decode_stage.sv
// IF/ID pipeline register with a one-entry hold buffer, load-use stall,
// branch flush and RUN -> DRAIN -> HALTED halt sequencing.
module if_id_decode_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W       = INSTR_W,
    parameter int unsigned PC_W         = PC_AW,
    parameter int unsigned REG_AW       = RF_AW,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] if_instr,
    input  logic [PC_W-1:0]   if_pc,
    input  logic              if_valid,
    input  logic              if_done,
    input  logic              ex_stall,
    input  logic              br_flush,
    output logic              id_valid,
    output logic [4:0]        id_opcode,
    output logic [REG_AW-1:0] id_rd,
    output logic [REG_AW-1:0] id_rs1,
    output logic [REG_AW-1:0] id_rs2,
    output logic [DATA_W-1:0] id_imm,
    output logic [PC_W-1:0]   id_pc,
    output logic              stall_fetch,
    output logic              halted
);

    localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

    logic              id_valid_q, id_valid_d;
    logic [DATA_W-1:0] id_instr_q, id_instr_d;
    logic [PC_W-1:0]   id_pc_q, id_pc_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] hold_instr_q, hold_instr_d;
    logic [PC_W-1:0]   hold_pc_q, hold_pc_d;
    halt_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              fetch_ok;
    logic              src_valid;
    logic [DATA_W-1:0] src_instr;
    logic [PC_W-1:0]   src_pc;
    logic              hazard;

    // A full hold buffer always issues first; while it is full the word on
    // if_instr is the one fetch keeps re-presenting and is ignored.
    always_comb begin
        fetch_ok  = if_valid && (state_q == ST_RUN);
        src_valid = hold_full_q || fetch_ok;
        src_instr = hold_full_q ? hold_instr_q : if_instr;
        src_pc    = hold_full_q ? hold_pc_q    : if_pc;
    end

    id_hazard_detect u_hazard (
        .id_valid  (id_valid_q),
        .id_opcode (id_instr_q[OPC_LSB +: OPC_W]),
        .id_rd     (id_instr_q[RD_LSB +: REG_AW]),
        .src_valid (src_valid),
        .src_rs1   (src_instr[RS1_LSB +: REG_AW]),
        .src_rs2   (src_instr[RS2_LSB +: REG_AW]),
        .hazard    (hazard)
    );

    always_comb begin
        id_valid_d   = id_valid_q;
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;
        hold_full_d  = hold_full_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        stall_fetch  = 1'b0;

        if (state_q == ST_HALTED) begin
            id_valid_d  = 1'b0;
            hold_full_d = 1'b0;
            stall_fetch = 1'b1;
        end else if (br_flush) begin
            id_valid_d  = 1'b0;
            hold_full_d = 1'b0;
            if (state_q == ST_DRAIN) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        end else begin
            if (ex_stall || hazard) begin
                stall_fetch = 1'b1;
                if (!ex_stall) begin
                    id_valid_d = 1'b0;
                end
                if (!hold_full_q && fetch_ok) begin
                    hold_full_d  = 1'b1;
                    hold_instr_d = if_instr;
                    hold_pc_d    = if_pc;
                end
            end else begin
                id_valid_d  = src_valid;
                hold_full_d = 1'b0;
                if (src_valid) begin
                    id_instr_d = src_instr;
                    id_pc_d    = src_pc;
                end
            end

            case (state_q)
                ST_RUN: begin
                    if (if_done) begin
                        state_d = ST_DRAIN;
                        cnt_d   = '0;
                    end
                end
                ST_DRAIN: begin
                    if (!ex_stall && !hold_full_q) begin
                        if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
                            state_d = ST_HALTED;
                            cnt_d   = CNT_W'(DRAIN_CYCLES);
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid_q   <= 1'b0;
            id_instr_q   <= '0;
            id_pc_q      <= '0;
            hold_full_q  <= 1'b0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            state_q      <= ST_RUN;
            cnt_q        <= '0;
        end else begin
            id_valid_q   <= id_valid_d;
            id_instr_q   <= id_instr_d;
            id_pc_q      <= id_pc_d;
            hold_full_q  <= hold_full_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        id_valid  = id_valid_q;
        id_opcode = id_instr_q[OPC_LSB +: OPC_W];
        id_rd     = id_instr_q[RD_LSB +: REG_AW];
        id_rs1    = id_instr_q[RS1_LSB +: REG_AW];
        id_rs2    = id_instr_q[RS2_LSB +: REG_AW];
        id_imm    = sext_imm(id_instr_q);
        id_pc     = id_pc_q;
        halted    = (state_q == ST_HALTED);
    end

endmodule

// File: tb/tb_if_id_decode_stage.sv
// Directed bench for if_id_decode_stage with hand-computed expectations.
module tb_if_id_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_instr;
    logic [6:0]  if_pc;
    logic        if_valid, if_done, ex_stall, br_flush;
    logic        id_valid;
    logic [4:0]  id_opcode;
    logic [3:0]  id_rd, id_rs1, id_rs2;
    logic [31:0] id_imm;
    logic [6:0]  id_pc;
    logic        stall_fetch, halted;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    if_id_decode_stage #(.DRAIN_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n), .if_instr(if_instr), .if_pc(if_pc),
        .if_valid(if_valid), .if_done(if_done), .ex_stall(ex_stall), .br_flush(br_flush),
        .id_valid(id_valid), .id_opcode(id_opcode), .id_rd(id_rd), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_imm(id_imm), .id_pc(id_pc),
        .stall_fetch(stall_fetch), .halted(halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [3:0] rs2,
                                       input logic [14:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    task automatic drive(input logic [31:0] instr, input logic [6:0] pc, input logic v);
        if_instr = instr;
        if_pc    = pc;
        if_valid = v;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    localparam logic [4:0] ADD  = 5'b00001;
    localparam logic [4:0] LOAD = 5'b00100;

    logic [31:0] add_v [4];
    logic [14:0] imm_v [4];
    logic [31:0] imm_x [4];

    initial begin
        rst_n = 1'b0; if_done = 0; ex_stall = 0; br_flush = 0;
        drive('0, '0, 1'b0);
        imm_v[0] = 15'h7FFF; imm_x[0] = 32'hFFFF_FFFF;
        imm_v[1] = 15'h0005; imm_x[1] = 32'h0000_0005;
        imm_v[2] = 15'h4000; imm_x[2] = 32'hFFFF_C000;
        imm_v[3] = 15'h3FFF; imm_x[3] = 32'h0000_3FFF;
        #12;
        check("rst_id_valid", 32'(id_valid), 0);
        check("rst_id_opcode", 32'(id_opcode), 0);
        check("rst_id_imm", id_imm, 0);
        check("rst_id_pc", 32'(id_pc), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_stall_fetch", 32'(stall_fetch), 0);
        rst_n = 1'b1;
        tick;

        // 1: back-to-back ADDs
        for (int i = 0; i < 4; i++) begin
            add_v[i] = mk(ADD, 4'(i + 1), 4'(i + 6), 4'(i + 10), imm_v[i]);
            drive(add_v[i], 7'(i), 1'b1);
            tick;
            check("add_valid", 32'(id_valid), 1);
            check("add_pc", 32'(id_pc), 32'(i));
            check("add_opcode", 32'(id_opcode), 32'(ADD));
            check("add_rd", 32'(id_rd), 32'(i + 1));
            check("add_rs1", 32'(id_rs1), 32'(i + 6));
            check("add_rs2", 32'(id_rs2), 32'(i + 10));
            check("add_imm", id_imm, imm_x[i]);
        end
        drive('0, '0, 1'b0);
        tick;
        check("idle_valid", 32'(id_valid), 0);

        // 2: load-use
        drive(mk(LOAD, 4'd5, 4'd1, 4'd2, 15'd0), 7'd0, 1'b1);
        #1 check("lu_no_stall_first", 32'(stall_fetch), 0);
        tick;
        drive(mk(ADD, 4'd6, 4'd5, 4'd0, 15'd1), 7'd1, 1'b1);
        #1 check("lu_stall", 32'(stall_fetch), 1);
        tick;
        check("lu_bubble", 32'(id_valid), 0);
        #1 check("lu_stall_one_cycle", 32'(stall_fetch), 0);
        tick;
        check("lu_add_valid", 32'(id_valid), 1);
        check("lu_add_pc", 32'(id_pc), 1);
        check("lu_add_rs1", 32'(id_rs1), 5);
        drive(mk(LOAD, 4'd0, 4'd1, 4'd1, 15'd0), 7'd3, 1'b1);
        tick;
        drive(mk(ADD, 4'd2, 4'd0, 4'd0, 15'd0), 7'd4, 1'b1);
        #1 check("lu_rd0_no_stall", 32'(stall_fetch), 0);
        tick;
        check("lu_rd0_pc", 32'(id_pc), 4);
        check("lu_rd0_valid", 32'(id_valid), 1);

        // 3: ex_stall for three cycles
        drive(mk(ADD, 4'd1, 4'd2, 4'd3, 15'd10), 7'd10, 1'b1);
        tick;
        ex_stall = 1'b1;
        drive(mk(ADD, 4'd1, 4'd2, 4'd3, 15'd11), 7'd11, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1 check("exs_stall_fetch", 32'(stall_fetch), 1);
            tick;
            check("exs_frozen_pc", 32'(id_pc), 10);
            check("exs_frozen_valid", 32'(id_valid), 1);
            check("exs_frozen_imm", id_imm, 10);
        end
        ex_stall = 1'b0;
        drive('0, '0, 1'b0);
        tick;
        check("exs_hold_valid", 32'(id_valid), 1);
        check("exs_hold_pc", 32'(id_pc), 11);
        check("exs_hold_imm", id_imm, 11);
        drive(mk(ADD, 4'd1, 4'd2, 4'd3, 15'd12), 7'd12, 1'b1);
        tick;
        check("exs_next_pc", 32'(id_pc), 12);

        // 4: flush with hold full
        ex_stall = 1'b1;
        drive(mk(ADD, 4'd1, 4'd2, 4'd3, 15'd13), 7'd13, 1'b1);
        tick;
        ex_stall = 1'b0; br_flush = 1'b1;
        drive(mk(ADD, 4'd1, 4'd2, 4'd3, 15'd14), 7'd14, 1'b1);
        #1 check("fl_stall_fetch", 32'(stall_fetch), 0);
        tick;
        check("fl_valid", 32'(id_valid), 0);
        br_flush = 1'b0;
        drive(mk(ADD, 4'd1, 4'd2, 4'd3, 15'd20), 7'd20, 1'b1);
        tick;
        check("fl_after_valid", 32'(id_valid), 1);
        check("fl_after_pc", 32'(id_pc), 20);

        // 5: halt sequencing
        drive('0, '0, 1'b0);
        if_done = 1'b1;
        tick;
        if_done = 1'b0;
        drive(mk(ADD, 4'd1, 4'd2, 4'd3, 15'd30), 7'd30, 1'b1);
        tick;
        check("drain_ignores_fetch", 32'(id_valid), 0);
        check("drain_halted_1", 32'(halted), 0);
        tick;
        check("drain_halted_2", 32'(halted), 0);
        tick;
        check("halted_set", 32'(halted), 1);
        check("halted_stall_fetch", 32'(stall_fetch), 1);
        br_flush = 1'b1;
        tick;
        br_flush = 1'b0;
        check("halted_sticky", 32'(halted), 1);
        check("halted_no_issue", 32'(id_valid), 0);

        // 6: async reset during DRAIN
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick;
        drive(mk(ADD, 4'd7, 4'd2, 4'd3, 15'd40), 7'd40, 1'b1);
        if_done = 1'b1;
        tick;
        if_done = 1'b0; ex_stall = 1'b1;
        drive('0, '0, 1'b0);
        tick;
        check("pre_rst_valid", 32'(id_valid), 1);
        #2;
        rst_n = 1'b0; ex_stall = 1'b0;
        #1;
        check("arst_valid", 32'(id_valid), 0);
        check("arst_pc", 32'(id_pc), 0);
        check("arst_rd", 32'(id_rd), 0);
        check("arst_halted", 32'(halted), 0);
        check("arst_stall_fetch", 32'(stall_fetch), 0);
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick;
        check("post_rst_not_halted", 32'(halted), 0);
        drive(mk(ADD, 4'd1, 4'd2, 4'd3, 15'd50), 7'd50, 1'b1);
        tick;
        check("post_rst_issue_valid", 32'(id_valid), 1);
        check("post_rst_issue_pc", 32'(id_pc), 50);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
